// File: rtl/clk_div_event_gen_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_p
// Shared types and helpers for the clk_div_event_gen divider sequencer.
//   state_e    : sequencer state (IDLE, HIGH, LOW)
//   DEF_CNT_W  : default width of the high/low phase length counters
//   clamp_len  : maps a zero phase length to one (a phase is never empty)
// -----------------------------------------------------------------------------
package clk_div_p;

  localparam int DEF_CNT_W = 16;

  // Width used by clamp_len; callers with narrower counters cast in and out,
  // so counter widths up to CLAMP_W are supported.
  localparam int CLAMP_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  function automatic logic [CLAMP_W-1:0] clamp_len(input logic [CLAMP_W-1:0] len);
    return (len == '0) ? CLAMP_W'(1) : len;
  endfunction

endpackage

// File: rtl/clk_div_event_gen_phase_counter.sv
// -----------------------------------------------------------------------------
// phase_counter
// Loadable down-counter that times one phase of the divided clock. It only
// moves on active cycles (clk_en high) and parks at zero.
//   clk, arst_n  : clock, asynchronous active-low reset (counter -> 0)
//   clk_en       : clock qualifier; counter holds while low
//   load_i       : load load_val_i on the next active edge (wins over decrement)
//   load_val_i   : value to load (phase length - 1)
//   zero_o       : counter currently reads zero (last cycle of the phase)
// -----------------------------------------------------------------------------
module phase_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             clk_en,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] cnt_q;

  // NOTE: every variable written in an always_comb gets its default on the
  // first line, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clk_en) begin
      if (load_i) begin
        cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/clk_div_event_gen.sv
// -----------------------------------------------------------------------------
// clk_div_event_gen
// Programmable divider sequencer driving a downstream set/clear/toggle
// flip-flop. It issues one-cycle set/clear strobes so the flip-flop output is
// high for exactly active_high and low for exactly active_low active cycles
// (cycles with clk_en high). New duty settings are double-buffered and only
// take effect at a period boundary or on return to IDLE, so no runt pulses.
//
// Ports:
//   clk, arst_n      : clock, asynchronous active-low reset
//   clk_en           : clock qualifier; all state advances only when high
//   enable_i         : run request (level)
//   cfg_load_i       : capture high_cycles_i / low_cycles_i (0 is taken as 1)
//   high_cycles_i    : requested high-phase length
//   low_cycles_i     : requested low-phase length
//   set_en_o         : strobe, drive downstream flip-flop high
//   clear_en_o       : strobe, drive downstream flip-flop low
//   period_done_o    : strobe on the final cycle of each LOW phase
//   running_o        : sequencer is not IDLE
//   cfg_pending_o    : a captured configuration is waiting for a boundary
//
// Build option:
//   CLK_DIV_GLITCHLESS_STOP_EN : when defined, dropping enable_i never cuts a
//   period short; the sequencer completes HIGH and LOW and stops at the LOW
//   end. When undefined, dropping enable_i in HIGH clears the output at once
//   and dropping it in LOW stops immediately without period_done_o.
// -----------------------------------------------------------------------------
module clk_div_event_gen
  import clk_div_p::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int DEF_HIGH = 1,
  parameter int DEF_LOW  = 1
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             clk_en,
  input  logic             enable_i,
  input  logic             cfg_load_i,
  input  logic [CNT_W-1:0] high_cycles_i,
  input  logic [CNT_W-1:0] low_cycles_i,
  output logic             set_en_o,
  output logic             clear_en_o,
  output logic             period_done_o,
  output logic             running_o,
  output logic             cfg_pending_o
);

  localparam logic [CNT_W-1:0] RST_HIGH = CNT_W'(clamp_len(CLAMP_W'(DEF_HIGH)));
  localparam logic [CNT_W-1:0] RST_LOW  = CNT_W'(clamp_len(CLAMP_W'(DEF_LOW)));

  state_e           state_d, state_q;
  logic [CNT_W-1:0] act_high_d, act_high_q;
  logic [CNT_W-1:0] act_low_d, act_low_q;
  logic [CNT_W-1:0] pend_high_d, pend_high_q;
  logic [CNT_W-1:0] pend_low_d, pend_low_q;
  logic             pend_d, pend_q;

  logic [CNT_W-1:0] cap_high, cap_low;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_zero;
  logic             set_en, clear_en, period_done;
  logic             go_idle, restart;

  assign cap_high = CNT_W'(clamp_len(CLAMP_W'(high_cycles_i)));
  assign cap_low  = CNT_W'(clamp_len(CLAMP_W'(low_cycles_i)));

  phase_counter #(
    .CNT_W (CNT_W)
  ) u_phase_counter (
    .clk        (clk),
    .arst_n     (arst_n),
    .clk_en     (clk_en),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    act_high_d   = act_high_q;
    act_low_d    = act_low_q;
    pend_high_d  = pend_high_q;
    pend_low_d   = pend_low_q;
    pend_d       = pend_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    set_en       = 1'b0;
    clear_en     = 1'b0;
    period_done  = 1'b0;
    go_idle      = 1'b0;
    restart      = 1'b0;

    if (clk_en) begin
      case (state_q)
        IDLE: begin
          if (cfg_load_i) begin
            act_high_d = cap_high;
            act_low_d  = cap_low;
          end
          if (enable_i) begin
            // A load in the same cycle as the start is used straight away.
            set_en       = 1'b1;
            state_d      = HIGH;
            cnt_load     = 1'b1;
            cnt_load_val = (cfg_load_i ? cap_high : act_high_q) - CNT_W'(1);
          end
        end
        HIGH: begin
`ifdef CLK_DIV_GLITCHLESS_STOP_EN
          if (cnt_zero) begin
`else
          if (!enable_i) begin
            clear_en = 1'b1;
            go_idle  = 1'b1;
          end else if (cnt_zero) begin
`endif
            clear_en     = 1'b1;
            state_d      = LOW;
            cnt_load     = 1'b1;
            cnt_load_val = act_low_q - CNT_W'(1);
          end
        end
        LOW: begin
`ifdef CLK_DIV_GLITCHLESS_STOP_EN
          if (cnt_zero) begin
`else
          if (!enable_i) begin
            go_idle = 1'b1;
          end else if (cnt_zero) begin
`endif
            period_done = 1'b1;
            restart     = enable_i;
            go_idle     = !enable_i;
          end
        end
        default: go_idle = 1'b1;
      endcase

      // While running, loads land in the shadow registers (last one wins).
      if (state_q != IDLE && cfg_load_i) begin
        pend_high_d = cap_high;
        pend_low_d  = cap_low;
        pend_d      = 1'b1;
      end

      // Period boundary: promote the shadow captured before this cycle; a load
      // arriving on the boundary itself stays pending for the next one.
      if (restart) begin
        set_en   = 1'b1;
        state_d  = HIGH;
        cnt_load = 1'b1;
        if (pend_q) begin
          act_high_d   = pend_high_q;
          act_low_d    = pend_low_q;
          cnt_load_val = pend_high_q - CNT_W'(1);
        end else begin
          cnt_load_val = act_high_q - CNT_W'(1);
        end
        if (!cfg_load_i) begin
          pend_d = 1'b0;
        end
      end

      // Stopping: nothing is left to protect, so the newest config goes live.
      if (go_idle) begin
        state_d = IDLE;
        if (cfg_load_i) begin
          act_high_d = cap_high;
          act_low_d  = cap_low;
        end else if (pend_q) begin
          act_high_d = pend_high_q;
          act_low_d  = pend_low_q;
        end
        pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= IDLE;
      act_high_q  <= RST_HIGH;
      act_low_q   <= RST_LOW;
      pend_high_q <= '0;
      pend_low_q  <= '0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_high_q  <= act_high_d;
      act_low_q   <= act_low_d;
      pend_high_q <= pend_high_d;
      pend_low_q  <= pend_low_d;
      pend_q      <= pend_d;
    end
  end

  // Strobes are Mealy decodes; they are masked during reset so an enable held
  // high while arst_n is low cannot pulse the downstream flip-flop.
  assign set_en_o      = set_en & arst_n;
  assign clear_en_o    = clear_en & arst_n;
  assign period_done_o = period_done & arst_n;
  assign running_o     = (state_q != IDLE);
  assign cfg_pending_o = pend_q;

endmodule
